pc_fetch_unit: RTL and testbench

//  Holds the architectural PC and runs instruction fetch. Drives pc_o into NPC and loads NPC's npc_i result when decode accepts an instruction.

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_if.sv | 32 +++
 rtl/pc_fetch_unit_if_hold_reg.sv | 47 ++++
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module  : pc_fetch_unit_pkg
// Brief   : Shared fetch-stage types and constants (FSM encoding, reset PC).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    localparam logic [31:0] c_default_reset_pc = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    function automatic logic [29:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module  : pc_fetch_unit_if
// Brief   : Instruction-memory request/response and decode handoff bundle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [29:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        id_ready_i;

    // Fetch-unit side
    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );

    // Memory / decode side
    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit_if_hold_reg.sv
// ============================================================================
// Module  : if_hold_reg
// Brief   : Valid/ready hold register for the {pc, instr} pair shown to decode.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module if_hold_reg #(
    parameter logic [29:0] RESET_WORD = 30'h0000_0C00
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic        i_clear,
    input  wire logic [29:0] i_pc,
    input  wire logic [31:0] i_instr,
    output logic             o_valid,
    output logic [29:0]      o_pc,
    output logic [31:0]      o_instr
);

    logic        r_valid;
    logic [29:0] r_pc;
    logic [31:0] r_instr;

    // Load wins over clear; the FSM never asserts both in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_WORD;
            r_instr <= 32'h0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module  : pc_fetch_unit
// Brief   : Architectural PC holder and single-outstanding instruction fetch.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_default_reset_pc
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [29:0]  npc_i,
    output logic [29:0]       pc_o,
    pc_fetch_unit_if.master   bus,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [29:0] c_reset_word = byte_to_word(RESET_PC);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [29:0]  r_pc;
    logic [31:0]  r_fetch_cnt;
    logic [31:0]  r_stall_cnt;
    logic         w_req;
    logic         w_load;
    logic         w_handoff;
    logic         w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rvalid only matters in S_WAIT, or alongside gnt in S_REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_load      = 1'b0;
        w_handoff   = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = 1'b1;
                if (bus.imem_gnt_i) begin
                    if (bus.imem_rvalid_i) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_VALID;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.id_ready_i) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= c_reset_word;
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            if (w_handoff) begin
                r_pc        <= npc_i;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    if_hold_reg #(
        .RESET_WORD (c_reset_word)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_handoff),
        .i_pc    (r_pc),
        .i_instr (bus.imem_rdata_i),
        .o_valid (bus.if_valid_o),
        .o_pc    (bus.if_pc_o),
        .o_instr (bus.if_instr_o)
    );

    assign bus.imem_req_o  = w_req & ~rst;
    assign bus.imem_addr_o = r_pc;
    assign pc_o            = r_pc;
    assign fetch_cnt_o     = r_fetch_cnt;
    assign stall_cnt_o     = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module  : tb_pc_fetch_unit
// Brief   : Directed self-checking bench with a transaction-level fetch model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] npc_i;
    logic [29:0] pc_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_pass;
    int n_total;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc_i       (npc_i),
        .pc_o        (pc_o),
        .bus         (bus.master),
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: the fetch unit either owns a presented instruction, is owed a
    // response for a granted request, or is asking for its next PC.
    bit          m_known;
    bit          m_presenting;
    bit          m_owed;
    logic [29:0] m_pc;
    logic [29:0] m_if_pc;
    logic [31:0] m_instr;
    int unsigned m_fetches;
    int unsigned m_stalls;

    always @(posedge clk) begin
        if (rst) begin
            m_known      = 1'b1;
            m_presenting = 1'b0;
            m_owed       = 1'b0;
            m_pc         = 30'h0C00;
            m_if_pc      = 30'h0C00;
            m_instr      = 32'h0;
            m_fetches    = 0;
            m_stalls     = 0;
        end else if (m_known) begin
            if (m_presenting) begin
                if (bus.id_ready_i) begin
                    m_pc         = npc_i;
                    m_fetches    = m_fetches + 1;
                    m_presenting = 1'b0;
                end else begin
                    m_stalls = m_stalls + 1;
                end
            end else if (m_owed || bus.imem_gnt_i) begin
                if (bus.imem_rvalid_i) begin
                    m_presenting = 1'b1;
                    m_owed       = 1'b0;
                    m_instr      = bus.imem_rdata_i;
                    m_if_pc      = m_pc;
                end else begin
                    m_owed = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model.req",    {31'h0, bus.imem_req_o}, {31'h0, (!rst && !m_presenting && !m_owed)});
            chk("model.addr",   {2'b0, bus.imem_addr_o}, {2'b0, m_pc});
            chk("model.pc_o",   {2'b0, pc_o},            {2'b0, m_pc});
            chk("model.valid",  {31'h0, bus.if_valid_o}, {31'h0, m_presenting});
            if (m_presenting) begin
                chk("model.if_pc",  {2'b0, bus.if_pc_o}, {2'b0, m_if_pc});
                chk("model.instr",  bus.if_instr_o,      m_instr);
            end
            chk("model.fetch_cnt", fetch_cnt_o, m_fetches);
            chk("model.stall_cnt", stall_cnt_o, m_stalls);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Grant now, respond one cycle later; leaves the unit presenting.
    task automatic fetch(input logic [31:0] data);
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = data;
        tick();
        bus.imem_rvalid_i = 1'b0;
    endtask

    task automatic handoff(input logic [29:0] npc);
        bus.id_ready_i = 1'b1;
        npc_i          = npc;
        tick();
        bus.id_ready_i = 1'b0;
        npc_i          = 30'h1555_5555;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst               = 1'b1;
        npc_i             = 30'h0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.id_ready_i    = 1'b0;
        #1;
        chk("rst.req_forced", {31'h0, bus.imem_req_o}, 32'h0);
        tick(2);
        chk("rst.valid",     {31'h0, bus.if_valid_o}, 32'h0);
        chk("rst.if_pc",     {2'b0, bus.if_pc_o},     32'h0000_0C00);
        chk("rst.instr",     bus.if_instr_o,          32'h0);
        chk("rst.fetch_cnt", fetch_cnt_o,             32'h0);
        rst = 1'b0;
        #1;
        chk("t1.req",  {31'h0, bus.imem_req_o},  32'h1);
        chk("t1.addr", {2'b0, bus.imem_addr_o},  32'h0000_0C00);

        // Test 1: first fetch from the reset PC
        fetch(32'h2008_0005);
        chk("t1.valid", {31'h0, bus.if_valid_o}, 32'h1);
        chk("t1.if_pc", {2'b0, bus.if_pc_o},     32'h0000_0C00);
        chk("t1.instr", bus.if_instr_o,          32'h2008_0005);

        // Test 2: sequential handoff
        handoff(30'h0C01);
        chk("t2.addr",  {2'b0, bus.imem_addr_o}, 32'h0000_0C01);
        chk("t2.fetch", fetch_cnt_o,             32'd1);
        chk("t2.valid", {31'h0, bus.if_valid_o}, 32'h0);

        // Test 3: branch target replaces the sequential PC
        fetch(32'h1111_0001);
        chk("t3.if_pc", {2'b0, bus.if_pc_o}, 32'h0000_0C01);
        handoff(30'h0BFC);
        chk("t3.addr",  {2'b0, bus.imem_addr_o}, 32'h0000_0BFC);
        chk("t3.fetch", fetch_cnt_o,             32'd2);

        // Test 4: decode stalls, with a spurious rvalid mid-stall
        fetch(32'h3333_0003);
        for (int i = 0; i < 5; i++) begin
            bus.imem_rvalid_i = (i == 2);
            bus.imem_rdata_i  = 32'hDEAD_BEEF;
            tick();
            chk("t4.req",   {31'h0, bus.imem_req_o}, 32'h0);
            chk("t4.if_pc", {2'b0, bus.if_pc_o},     32'h0000_0BFC);
            chk("t4.instr", bus.if_instr_o,          32'h3333_0003);
        end
        bus.imem_rvalid_i = 1'b0;
        chk("t4.stall", stall_cnt_o, 32'd5);
        handoff(30'h3FFF_FFFF);
        chk("t4.addr_max", {2'b0, bus.imem_addr_o}, 32'h3FFF_FFFF);

        // Test 5: no grant for 3 cycles while rvalid is spuriously high
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5.req_held", {31'h0, bus.imem_req_o}, 32'h1);
            chk("t5.valid",    {31'h0, bus.if_valid_o}, 32'h0);
        end
        bus.imem_gnt_i   = 1'b1;
        bus.imem_rdata_i = 32'h4444_0004;
        tick();
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        chk("t5.valid_now", {31'h0, bus.if_valid_o}, 32'h1);
        chk("t5.if_pc",     {2'b0, bus.if_pc_o},     32'h3FFF_FFFF);
        chk("t5.instr",     bus.if_instr_o,          32'h4444_0004);
        handoff(30'h0);
        chk("t5.wrap_addr", {2'b0, bus.imem_addr_o}, 32'h0);
        chk("t5.fetch",     fetch_cnt_o,             32'd4);

        // Test 6: reset while waiting for a response
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6.req_forced", {31'h0, bus.imem_req_o}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6.addr",  {2'b0, bus.imem_addr_o}, 32'h0000_0C00);
        chk("t6.valid", {31'h0, bus.if_valid_o}, 32'h0);
        chk("t6.fetch", fetch_cnt_o,             32'h0);
        chk("t6.stall", stall_cnt_o,             32'h0);
        chk("t6.req",   {31'h0, bus.imem_req_o}, 32'h1);

        // Slow memory after reset: late grant, late response
        tick(2);
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        tick(2);
        chk("t7.waiting", {31'h0, bus.if_valid_o}, 32'h0);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'h5555_0005;
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("t7.instr", bus.if_instr_o, 32'h5555_0005);
        tick();
        handoff(30'h0C08);
        chk("t7.stall", stall_cnt_o, 32'd1);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
